// File: rtl/entropy_decoding.sv
// Baseline JPEG Huffman entropy decoder: bit buffer, parallel table match, amplitude decode
// and de-zigzag into 8x8 quantized coefficient blocks, one component at a time.
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif
`ifndef CH
`define CH 3
`endif

package sys_defs_pkg;
  typedef struct packed {
    logic [15:0] code;
    logic [7:0]  symbol;
    logic [4:0]  size;
  } huff_entry_t;

  typedef struct packed {
    huff_entry_t [11:0]  dc_tab;
    huff_entry_t [161:0] ac_tab;
  } huff_tab_t;

  typedef struct packed {
    logic [`CH-1:0]  map;
    huff_tab_t [1:0] tabs;
    logic [4:0]      dc_size;
    logic [7:0]      ac_size;
  } HUFF_PACKET;
endpackage

module entropy_decoding
  import sys_defs_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [`IN_BUS_WIDTH-1:0]      data_in,
  input  logic                          valid_in,
  input  HUFF_PACKET                    hp,
  output logic signed [7:0][7:0][11:0]  block,
  output logic                          valid_out,
  output logic                          request,
  output logic [$clog2(`CH+1)-1:0]      ch
);
  localparam int unsigned W     = `IN_BUS_WIDTH;
  localparam int unsigned BW    = 2 * W;
  localparam int unsigned CntW  = $clog2(BW + 1);
  localparam int unsigned ChW   = $clog2(`CH + 1);
  localparam int unsigned NumCh = `CH;

  // Zigzag scan index -> natural (row*8 + col) position.
  localparam logic [5:0] ZigZag [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10, 6'd17, 6'd24, 6'd32, 6'd25, 6'd18,
    6'd11, 6'd4,  6'd5,  6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd27, 6'd20,
    6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43,
    6'd36, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51, 6'd58, 6'd59, 6'd52, 6'd45,
    6'd38, 6'd31, 6'd39, 6'd46, 6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {StDc, StAc, StEmit} state_e;

  state_e                 state_q;
  logic [BW-1:0]          bits_q, bits_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [6:0]             k_q;
  logic [ChW-1:0]         comp_q, ch_q;
  logic [NumCh-1:0][11:0] pred_q;
  logic [63:0][11:0]      work_q;
  logic [7:0][7:0][11:0]  block_q;
  logic                   valid_q;

  function automatic logic entry_hit(input huff_entry_t e, input logic in_range,
                                     input logic [31:0] win, input logic [CntW-1:0] cnt);
    logic [31:0] mask;
    mask = (32'd1 << e.size) - 32'd1;
    return in_range && (e.size != 5'd0) && (CntW'(e.size) <= cnt) &&
           ((({16'd0, e.code} ^ win) & mask) == 32'd0);
  endfunction

  logic       tab_sel;
  logic       hit;
  logic [4:0] hit_size;
  logic [7:0] hit_sym;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    tab_sel  = hp.map[comp_q];
    hit      = 1'b0;
    hit_size = '0;
    hit_sym  = '0;
    if (state_q == StDc) begin
      for (int i = 11; i >= 0; i--) begin
        if (entry_hit(hp.tabs[tab_sel].dc_tab[i], i < int'(hp.dc_size), bits_q[31:0], cnt_q)) begin
          hit      = 1'b1;
          hit_size = hp.tabs[tab_sel].dc_tab[i].size;
          hit_sym  = hp.tabs[tab_sel].dc_tab[i].symbol;
        end
      end
    end else if (state_q == StAc) begin
      for (int i = 161; i >= 0; i--) begin
        if (entry_hit(hp.tabs[tab_sel].ac_tab[i], i < int'(hp.ac_size), bits_q[31:0], cnt_q)) begin
          hit      = 1'b1;
          hit_size = hp.tabs[tab_sel].ac_tab[i].size;
          hit_sym  = hp.tabs[tab_sel].ac_tab[i].symbol;
        end
      end
    end
  end

  logic [3:0]      amp_len;
  logic [CntW-1:0] need, consumed, cnt_left;
  logic            can_go, accept;
  logic [15:0]     after_code, rev, raw, amp_mask;
  logic [11:0]     amp_val, dc_sum;
  logic [6:0]      ac_pos;

  always_comb begin
    amp_len    = hit_sym[3:0];
    need       = CntW'(hit_size) + CntW'(amp_len);
    can_go     = hit && (need <= cnt_q);
    consumed   = can_go ? need : '0;
    after_code = 16'(bits_q >> hit_size);
    // The first amplitude bit is the MSB, so reverse the field before use.
    rev        = {<<{after_code}};
    raw        = rev >> (5'd16 - {1'b0, amp_len});
    amp_mask   = (16'd1 << amp_len) - 16'd1;
    if (amp_len == 4'd0)    amp_val = '0;
    else if (after_code[0]) amp_val = 12'(raw);
    else                    amp_val = 12'(raw - amp_mask);
    ac_pos   = k_q + {3'd0, hit_sym[7:4]};
    dc_sum   = pred_q[comp_q] + amp_val;

    accept   = request && valid_in;
    cnt_left = cnt_q - consumed;
    bits_d   = bits_q >> consumed;
    cnt_d    = cnt_left;
    if (accept) begin
      bits_d = bits_d | ({{W{1'b0}}, data_in} << cnt_left);
      cnt_d  = cnt_left + CntW'(W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StDc;
      bits_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      comp_q  <= '0;
      ch_q    <= '0;
      pred_q  <= '0;
      work_q  <= '0;
      block_q <= '0;
      valid_q <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        StDc: begin
          if (can_go) begin
            work_q[0]      <= dc_sum;
            pred_q[comp_q] <= dc_sum;
            k_q            <= 7'd1;
            state_q        <= StAc;
          end
        end
        StAc: begin
          if (can_go) begin
            if (hit_sym == 8'h00) begin
              state_q <= StEmit;
            end else if (hit_sym == 8'hF0) begin
              if (k_q >= 7'd48) begin
                k_q     <= 7'd64;
                state_q <= StEmit;
              end else begin
                k_q <= k_q + 7'd16;
              end
            end else if (ac_pos > 7'd63) begin
              k_q     <= 7'd64;
              state_q <= StEmit;
            end else begin
              work_q[ZigZag[ac_pos[5:0]]] <= amp_val;
              k_q                         <= ac_pos + 7'd1;
              if (ac_pos == 7'd63) state_q <= StEmit;
            end
          end
        end
        StEmit: begin
          block_q <= work_q;
          valid_q <= 1'b1;
          ch_q    <= comp_q;
          comp_q  <= (comp_q == ChW'(NumCh - 1)) ? '0 : comp_q + 1'b1;
          work_q  <= '0;
          k_q     <= '0;
          state_q <= StDc;
        end
        default: state_q <= StDc;
      endcase
    end
  end

  assign request   = (cnt_q <= CntW'(W));
  assign block     = block_q;
  assign valid_out = valid_q;
  assign ch        = ch_q;

endmodule

// File: tb/tb_entropy_decoding.sv
// Directed bench for entropy_decoding: hand-built bit streams against hand-computed blocks.
module tb_entropy_decoding;
  import sys_defs_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           data_in;
  logic                  valid_in;
  HUFF_PACKET            hp;
  logic [7:0][7:0][11:0] block;
  logic                  valid_out;
  logic                  request;
  logic [1:0]            ch;

  int n_total = 0;
  int n_bad   = 0;
  logic [767:0] cap_blk[$];
  int           cap_ch[$];

  always #5 clk = ~clk;

  entropy_decoding dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .hp       (hp),
    .block    (block),
    .valid_out(valid_out),
    .request  (request),
    .ch       (ch)
  );

  always @(negedge clk) begin
    if (!rst && valid_out) begin
      cap_blk.push_back(block);
      cap_ch.push_back(int'(ch));
    end
  end

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic huff_entry_t ent(input string c, input logic [7:0] sym);
    huff_entry_t e;
    e        = '0;
    e.size   = 5'(c.len());
    e.symbol = sym;
    for (int i = 0; i < c.len(); i++) e.code[i] = (c[i] == "1");
    return e;
  endfunction

  function automatic logic [767:0] put(input logic [767:0] b, input int r, input int c,
                                       input logic [11:0] v);
    logic [767:0] o;
    o = b;
    o[(r * 8 + c) * 12 +: 12] = v;
    return o;
  endfunction

  function automatic logic [767:0] blk_at(input int i);
    if (i < cap_blk.size()) return cap_blk[i];
    return {768{1'b1}};
  endfunction

  function automatic int ch_at(input int i);
    if (i < cap_ch.size()) return cap_ch[i];
    return -1;
  endfunction

  task automatic push_word(input logic [31:0] w);
    bit done;
    done = 1'b0;
    @(negedge clk);
    data_in  = w;
    valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (request) begin
        @(posedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("request_wait", 768'd0, 768'd1);
  endtask

  // Pads the tail word with ones, which no loaded code can start a DC match with.
  task automatic send_stream(input string s);
    int          nw;
    logic [31:0] word;
    nw = (s.len() + 31) / 32;
    for (int w = 0; w < nw; w++) begin
      word = '1;
      for (int i = 0; i < 32; i++) begin
        if (w * 32 + i < s.len()) word[i] = (s[w * 32 + i] == "1");
      end
      push_word(word);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    cap_blk.delete();
    cap_ch.delete();
    rst = 1'b0;
  endtask

  task automatic expect_blocks(input string tag, input int n);
    for (int i = 0; i < 300 && cap_blk.size() < n; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check(tag, 768'(cap_blk.size()), 768'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  string dc_lum[12] = '{"00", "010", "011", "100", "101", "110", "1110", "11110", "111110",
                        "1111110", "11111110", "111111110"};
  string dc_chr[12] = '{"00", "01", "10", "110", "1110", "11110", "111110", "1111110",
                        "11111110", "111111110", "1111111110", "11111111110"};
  // Leading part of the standard AC tables plus ZRL; the vectors use nothing else.
  string      ac_lum_c[12] = '{"00", "01", "100", "1010", "1011", "1100", "11010", "11011",
                               "11100", "111010", "111011", "11111111001"};
  logic [7:0] ac_lum_s[12] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
                               8'h21, 8'h31, 8'h41, 8'hF0};
  string      ac_chr_c[6]  = '{"00", "01", "100", "1010", "1011", "1111111010"};
  logic [7:0] ac_chr_s[6]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h11, 8'hF0};

  logic [767:0] exp_blk;
  string        s29a;

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    hp       = '0;
    hp.map     = 3'b110;
    hp.dc_size = 5'd12;
    hp.ac_size = 8'd162;
    for (int i = 0; i < 12; i++) begin
      hp.tabs[0].dc_tab[i] = ent(dc_lum[i], 8'(i));
      hp.tabs[1].dc_tab[i] = ent(dc_chr[i], 8'(i));
      hp.tabs[0].ac_tab[i] = ent(ac_lum_c[i], ac_lum_s[i]);
    end
    for (int i = 0; i < 6; i++) hp.tabs[1].ac_tab[i] = ent(ac_chr_c[i], ac_chr_s[i]);

    #1;
    check("rst_block", block, 768'd0);
    check("rst_valid", valid_out, 768'd0);
    check("rst_ch", ch, 768'd0);
    check("rst_request", request, 768'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Y: DC cat 0, EOB.
    send_stream("001010");
    expect_blocks("t25_nblk", 1);
    check("t25_block", blk_at(0), 768'd0);
    check("t25_ch", 768'(ch_at(0)), 768'd0);

    // Y=3, Cb=0, Cr=0, then Y=3 on top of predictor 3 -> 6.
    do_reset();
    send_stream("01111101000000000011111010");
    expect_blocks("t26_nblk", 4);
    check("t26_y0", blk_at(0), put(768'd0, 0, 0, 12'd3));
    check("t26_ch0", 768'(ch_at(0)), 768'd0);
    check("t26_cb", blk_at(1), 768'd0);
    check("t26_ch1", 768'(ch_at(1)), 768'd1);
    check("t26_cr", blk_at(2), 768'd0);
    check("t26_ch2", 768'(ch_at(2)), 768'd2);
    check("t26_y1", blk_at(3), put(768'd0, 0, 0, 12'd6));
    check("t26_ch3", 768'(ch_at(3)), 768'd0);

    // DC amplitude "01" -> -2; AC 0x01 amplitude "0" -> -1 at zigzag 1.
    do_reset();
    send_stream("011010001010");
    expect_blocks("t27_nblk", 1);
    exp_blk = put(put(768'd0, 0, 0, 12'hFFE), 0, 1, 12'hFFF);
    check("t27_block", blk_at(0), exp_blk);

    // ZRL from k=1 -> k=17; zigzag 17 is natural position row 2, col 3.
    do_reset();
    send_stream("00111111110010011010");
    expect_blocks("t28_nblk", 1);
    check("t28_block", blk_at(0), put(768'd0, 2, 3, 12'd1));

    // First word ends two bits into a code; hold the feed, then finish it.
    do_reset();
    s29a = "100111";
    for (int i = 0; i < 8; i++) s29a = {s29a, "001"};
    s29a = {s29a, "00"};
    send_stream(s29a);
    repeat (10) @(negedge clk);
    check("t29_stall_req", request, 768'd1);
    check("t29_stall_nblk", 768'(cap_blk.size()), 768'd0);
    send_stream("10001010");
    expect_blocks("t29_nblk", 1);
    exp_blk = put(768'd0, 0, 0, 12'd7);
    exp_blk = put(exp_blk, 0, 1, 12'd1);
    exp_blk = put(exp_blk, 1, 0, 12'd1);
    exp_blk = put(exp_blk, 2, 0, 12'd1);
    exp_blk = put(exp_blk, 1, 1, 12'd1);
    exp_blk = put(exp_blk, 0, 2, 12'd1);
    exp_blk = put(exp_blk, 0, 3, 12'd1);
    exp_blk = put(exp_blk, 1, 2, 12'd1);
    exp_blk = put(exp_blk, 2, 1, 12'd1);
    exp_blk = put(exp_blk, 3, 0, 12'd1);
    exp_blk = put(exp_blk, 4, 0, 12'hFFF);
    check("t29_block", blk_at(0), exp_blk);

    // Reset clears the held block; then reset mid-AC after a DC of 7 was absorbed.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t30_rst_block", block, 768'd0);
    check("t30_rst_valid", valid_out, 768'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cap_blk.delete();
    cap_ch.delete();
    send_stream(s29a);
    repeat (10) @(negedge clk);
    check("t30_partial_nblk", 768'(cap_blk.size()), 768'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t30_rst_request", request, 768'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cap_blk.delete();
    cap_ch.delete();
    send_stream("001010");
    expect_blocks("t30_nblk", 1);
    check("t30_block", blk_at(0), 768'd0);
    check("t30_ch", 768'(ch_at(0)), 768'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
